// File: rtl/wb_byte_master_pkg.sv
// Shared Wishbone byte-master constants: command/status codes, bus constants and FSM encoding.
package wb_byte_master_pkg;

  localparam logic [7:0] CmdWrite  = 8'h01;
  localparam logic [7:0] CmdRead   = 8'h02;
  localparam logic [7:0] StatusOk  = 8'hA5;
  localparam logic [7:0] StatusErr = 8'hEE;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [1:0] BteLinear   = 2'b00;
  localparam logic [3:0] SelWord     = 4'hF;

  typedef enum logic [2:0] {
    StIdle,
    StAddr,
    StWdata,
    StBus,
    StResp
  } state_e;

  function automatic logic is_cmd(input logic [7:0] b);
    return (b == CmdWrite) || (b == CmdRead);
  endfunction

endpackage

// File: rtl/wb_byte_master.sv
// Byte-stream command interpreter driving single classic Wishbone cycles; replies on a byte stream.
module wb_byte_master
  import wb_byte_master_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic [31:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  output logic [3:0]  wbm_sel_o,
  output logic        wbm_we_o,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic [2:0]  wbm_cti_o,
  output logic [1:0]  wbm_bte_o,
  input  logic [31:0] wbm_dat_i,
  input  logic        wbm_ack_i,
  input  logic        wbm_err_i
);

  localparam logic [15:0] TmoLast = 16'(TIMEOUT - 1);

  state_e      state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic        is_write_q, is_write_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdat_q, wdat_d;
  logic [31:0] rdata_q, rdata_d;
  logic        we_q, we_d;
  logic        cyc_q, cyc_d;
  logic [15:0] tmo_q, tmo_d;
  logic        tx_valid_q, tx_valid_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic [2:0]  resp_left_q, resp_left_d;
  logic        start_bus;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    is_write_d  = is_write_q;
    addr_d      = addr_q;
    wdat_d      = wdat_q;
    rdata_d     = rdata_q;
    we_d        = we_q;
    cyc_d       = cyc_q;
    tmo_d       = tmo_q;
    tx_valid_d  = tx_valid_q;
    tx_data_d   = tx_data_q;
    resp_left_d = resp_left_q;
    start_bus   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (rx_valid) begin
          if (is_cmd(rx_data)) begin
            is_write_d = (rx_data == CmdWrite);
            cnt_d      = 2'd0;
            state_d    = StAddr;
          end else begin
            // Unknown command: swallow it and answer with a lone error byte.
            tx_valid_d  = 1'b1;
            tx_data_d   = StatusErr;
            resp_left_d = 3'd0;
            state_d     = StResp;
          end
        end
      end
      StAddr: begin
        if (rx_valid) begin
          addr_d = {addr_q[23:0], rx_data};
          cnt_d  = cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            if (is_write_q) state_d = StWdata;
            else            start_bus = 1'b1;
          end
        end
      end
      StWdata: begin
        if (rx_valid) begin
          wdat_d = {wdat_q[23:0], rx_data};
          cnt_d  = cnt_q + 2'd1;
          if (cnt_q == 2'd3) start_bus = 1'b1;
        end
      end
      StBus: begin
        // err beats ack; a late ack on the final timeout cycle still counts as success.
        if (wbm_err_i || (!wbm_ack_i && tmo_q == TmoLast)) begin
          cyc_d       = 1'b0;
          we_d        = 1'b0;
          tx_valid_d  = 1'b1;
          tx_data_d   = StatusErr;
          resp_left_d = 3'd0;
          state_d     = StResp;
        end else if (wbm_ack_i) begin
          cyc_d      = 1'b0;
          we_d       = 1'b0;
          tx_valid_d = 1'b1;
          tx_data_d  = StatusOk;
          if (is_write_q) begin
            resp_left_d = 3'd0;
          end else begin
            rdata_d     = wbm_dat_i;
            resp_left_d = 3'd4;
          end
          state_d = StResp;
        end else begin
          tmo_d = tmo_q + 16'd1;
        end
      end
      StResp: begin
        if (tx_valid_q && tx_ready) begin
          if (resp_left_q == 3'd0) begin
            tx_valid_d = 1'b0;
            state_d    = StIdle;
          end else begin
            tx_data_d   = rdata_q[31:24];
            rdata_d     = {rdata_q[23:0], 8'h00};
            resp_left_d = resp_left_q - 3'd1;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    if (start_bus) begin
      state_d = StBus;
      cyc_d   = 1'b1;
      we_d    = is_write_q;
      tmo_d   = 16'd0;
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q     <= StIdle;
      cnt_q       <= 2'd0;
      is_write_q  <= 1'b0;
      addr_q      <= 32'd0;
      wdat_q      <= 32'd0;
      rdata_q     <= 32'd0;
      we_q        <= 1'b0;
      cyc_q       <= 1'b0;
      tmo_q       <= 16'd0;
      tx_valid_q  <= 1'b0;
      tx_data_q   <= 8'd0;
      resp_left_q <= 3'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      is_write_q  <= is_write_d;
      addr_q      <= addr_d;
      wdat_q      <= wdat_d;
      rdata_q     <= rdata_d;
      we_q        <= we_d;
      cyc_q       <= cyc_d;
      tmo_q       <= tmo_d;
      tx_valid_q  <= tx_valid_d;
      tx_data_q   <= tx_data_d;
      resp_left_q <= resp_left_d;
    end
  end

  assign rx_ready  = (state_q == StIdle) || (state_q == StAddr) || (state_q == StWdata);
  assign tx_data   = tx_data_q;
  assign tx_valid  = tx_valid_q;
  assign wbm_adr_o = {addr_q[31:2], 2'b00};
  assign wbm_dat_o = wdat_q;
  assign wbm_sel_o = SelWord;
  assign wbm_we_o  = we_q;
  assign wbm_cyc_o = cyc_q;
  assign wbm_stb_o = cyc_q;
  assign wbm_cti_o = CTI_CLASSIC;
  assign wbm_bte_o = BteLinear;

endmodule
